// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operand fields for one cycle,
// with flush (highest priority), freeze (hold) and bubble/illegal-decode squashing.
module id_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic [3:0]        exec_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              status_w_en_in,
    input  logic              branch_taken_in,
    input  logic              imm_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        status_in,
    output logic              valid_out,
    output logic [3:0]        exec_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              status_w_en_out,
    output logic              branch_taken_out,
    output logic              imm_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [3:0]        status_out
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        exec_cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic              status_w_en;
        logic              branch_taken;
        logic              imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [3:0]        status;
    } stage_t;

    stage_t stage_d;
    stage_t stage_q;
    stage_t captured;

    // Bubbles never carry side effects, and a decode asking to both read and write
    // memory is squashed so it cannot touch memory or the register file.
    always_comb begin
        captured = '{
            valid:         valid_in,
            exec_cmd:      exec_cmd_in,
            mem_r_en:      mem_r_en_in,
            mem_w_en:      mem_w_en_in,
            wb_en:         wb_en_in,
            status_w_en:   status_w_en_in,
            branch_taken:  branch_taken_in,
            imm:           imm_in,
            pc:            pc_in,
            val_rn:        val_rn_in,
            val_rm:        val_rm_in,
            shift_operand: shift_operand_in,
            signed_imm_24: signed_imm_24_in,
            dest:          dest_in,
            src1:          src1_in,
            src2:          src2_in,
            status:        status_in
        };
        if (!valid_in) begin
            captured.mem_r_en     = 1'b0;
            captured.mem_w_en     = 1'b0;
            captured.wb_en        = 1'b0;
            captured.status_w_en  = 1'b0;
            captured.branch_taken = 1'b0;
        end else if (mem_r_en_in && mem_w_en_in) begin
            captured.mem_r_en = 1'b0;
            captured.mem_w_en = 1'b0;
            captured.wb_en    = 1'b0;
        end

        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!freeze) begin
            stage_d = captured;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_out         = stage_q.valid;
    assign exec_cmd_out      = stage_q.exec_cmd;
    assign mem_r_en_out      = stage_q.mem_r_en;
    assign mem_w_en_out      = stage_q.mem_w_en;
    assign wb_en_out         = stage_q.wb_en;
    assign status_w_en_out   = stage_q.status_w_en;
    assign branch_taken_out  = stage_q.branch_taken;
    assign imm_out           = stage_q.imm;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign shift_operand_out = stage_q.shift_operand;
    assign signed_imm_24_out = stage_q.signed_imm_24;
    assign dest_out          = stage_q.dest;
    assign src1_out          = stage_q.src1;
    assign src2_out          = stage_q.src2;
    assign status_out        = stage_q.status;

endmodule
